stream_sink_ctrl: RTL and testbench



---
 rtl/stream_sink_ctrl_pkg.sv | 29 ++
 rtl/stream_sink_rr_sel.sv | 19 +
 rtl/stream_sink_ctrl.sv | 115 +++++++++++
 tb/tb_stream_sink_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/stream_sink_ctrl_pkg.sv
// rtl/stream_sink_ctrl_pkg.sv - shared FSM encoding and rotating first-one search
package stream_sink_ctrl_pkg;

  localparam int MaxInp = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCEPT = 2'd2
  } state_e;

  // First set bit of valid[n-1:0], scanning upward from start and wrapping.
  function automatic int rr_first(input logic [MaxInp-1:0] valid, input int start, input int n);
    int   idx;
    logic found;
    rr_first = 0;
    found    = 1'b0;
    for (int i = 0; i < MaxInp; i++) begin
      if (i < n && !found) begin
        idx = (start + i) % n;
        if (valid[idx]) begin
          found    = 1'b1;
          rr_first = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/stream_sink_rr_sel.sv
// rtl/stream_sink_rr_sel.sv - combinational rotate-priority selector
module stream_sink_rr_sel
  import stream_sink_ctrl_pkg::*;
#(
  parameter int NumInp   = 4,
  parameter int IdxWidth = 2
) (
  input  logic [NumInp-1:0]   valid_i,
  input  logic [IdxWidth-1:0] start_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_o
);

  always_comb begin
    idx_o = IdxWidth'(rr_first(MaxInp'(valid_i), int'(start_i), NumInp));
    any_o = |valid_i;
  end

endmodule

// File: rtl/stream_sink_ctrl.sv
// rtl/stream_sink_ctrl.sv - round-robin drain sink for tied-off stream ports
// STREAM_SINK_CTRL_CNT_EN builds the per-port saturating drop counters.
module stream_sink_ctrl
  import stream_sink_ctrl_pkg::*;
#(
  parameter int NumInp    = 4,
  parameter int DataWidth = 32,
  parameter int CntWidth  = 8,
  parameter int DrainLat  = 0,
  localparam int IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic [NumInp-1:0]             valid_i,
  input  logic [NumInp*DataWidth-1:0]   data_i,
  output logic [NumInp-1:0]             ready_o,
  output logic [NumInp-1:0]             seen_o,
  output logic [NumInp*CntWidth-1:0]    drop_cnt_o,
  output logic                          busy_o,
  output logic [IdxWidth-1:0]           last_idx_o
);

  state_e              state_q;
  logic [IdxWidth-1:0] gnt_q, rr_q, rr_next, sel_idx;
  logic                sel_any, hs;
  logic [7:0]          wait_q;
  logic [NumInp-1:0]   seen_q;
  logic                unused_data;

  assign unused_data = ^data_i;

  stream_sink_rr_sel #(.NumInp(NumInp), .IdxWidth(IdxWidth)) u_sel (
    .valid_i (valid_i),
    .start_i (rr_q),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  always_comb begin
    ready_o = '0;
    if (state_q == ACCEPT && en_i) ready_o = NumInp'(1) << gnt_q;
  end

  assign hs      = |(ready_o & valid_i);
  assign rr_next = (gnt_q == IdxWidth'(NumInp - 1)) ? '0 : gnt_q + IdxWidth'(1);
  assign busy_o  = (state_q != IDLE);
  assign seen_o  = seen_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      wait_q     <= '0;
      last_idx_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i && sel_any) begin
            gnt_q   <= sel_idx;
            wait_q  <= 8'(DrainLat);
            state_q <= (DrainLat == 0) ? ACCEPT : WAIT;
          end
        end
        WAIT: begin
          wait_q <= wait_q - 8'd1;
          if (!en_i)              state_q <= IDLE;
          else if (wait_q == 8'd1) state_q <= ACCEPT;
        end
        ACCEPT: begin
          state_q <= IDLE;
          // An aborted grant leaves rr_q alone so the same port is offered again.
          if (en_i) begin
            rr_q <= rr_next;
            if (hs) last_idx_o <= gnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      seen_q        <= '0;
    else if (flush_i) seen_q        <= '0;
    else if (hs)      seen_q[gnt_q] <= 1'b1;
  end

`ifdef STREAM_SINK_CTRL_CNT_EN
  logic [NumInp-1:0][CntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      cnt_q <= '0;
    else if (flush_i) cnt_q <= '0;
    else if (hs && cnt_q[gnt_q] != '1) cnt_q[gnt_q] <= cnt_q[gnt_q] + CntWidth'(1);
  end

  assign drop_cnt_o = cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ready_o));

  for (genvar i = 0; i < NumInp; i++) begin : g_stable
    a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      valid_i[i] && !ready_o[i] |=> valid_i[i])
      else $warning("port %0d dropped valid before handshake", i);
  end
`endif

endmodule

// File: tb/tb_stream_sink_ctrl.sv
// tb/tb_stream_sink_ctrl.sv - scoreboard bench for stream_sink_ctrl (STREAM_SINK_CTRL_CNT_EN aware)
module tb_stream_sink_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en_a = 1'b1, flush_a = 1'b0, en_b = 1'b1, flush_b = 1'b0;
  logic [3:0]   va = '0, vb = '0;
  logic [127:0] data = '0;

  logic [3:0]  ready_a, seen_a, ready_b, seen_b;
  logic [7:0]  cnt_a;
  logic [31:0] cnt_b;
  logic        busy_a, busy_b;
  logic [1:0]  last_a, last_b;

  int checks = 0;
  int errors = 0;
  int exp_a[$];
  int exp_b[$];

`ifdef STREAM_SINK_CTRL_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  always #5 clk = ~clk;

  stream_sink_ctrl #(.NumInp(4), .DataWidth(32), .CntWidth(2), .DrainLat(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .flush_i(flush_a), .valid_i(va), .data_i(data),
    .ready_o(ready_a), .seen_o(seen_a), .drop_cnt_o(cnt_a), .busy_o(busy_a), .last_idx_o(last_a)
  );

  stream_sink_ctrl #(.NumInp(4), .DataWidth(32), .CntWidth(8), .DrainLat(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .flush_i(flush_b), .valid_i(vb), .data_i(data),
    .ready_o(ready_b), .seen_o(seen_b), .drop_cnt_o(cnt_b), .busy_o(busy_b), .last_idx_o(last_b)
  );

  function automatic int ec(input int v);
    return CntEn ? v : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; va = '0; vb = '0;
    en_a = 1'b1; en_b = 1'b1; flush_a = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (ready_a & va) != 4'b0) begin
      if (exp_a.size() == 0) chk("a_unexpected_hs", 32'(ready_a), 32'd0);
      else chk("a_grant", 32'(ready_a), 32'd1 << exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && (ready_b & vb) != 4'b0) begin
      if (exp_b.size() == 0) chk("b_unexpected_hs", 32'(ready_b), 32'd0);
      else chk("b_grant", 32'(ready_b), 32'd1 << exp_b.pop_front());
    end
  end

  initial begin
    logic [3:0] acc;

    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_ready", 32'(ready_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_seen", 32'(seen_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);
    chk("rst_last", 32'(last_a), 0);
    chk("rst_ready_b", 32'(ready_b), 0);

    // single port 2, DrainLat 0
    step(); va = 4'b0100; exp_a.push_back(2);
    @(negedge clk); chk("s1_ready_c0", 32'(ready_a), 0);
    step(); @(negedge clk);
    chk("s1_ready_c1", 32'(ready_a), 32'b0100);
    chk("s1_busy_c1", 32'(busy_a), 1);
    step(); va = '0; @(negedge clk);
    chk("s1_cnt2", 32'(cnt_a[5:4]), ec(1));
    chk("s1_seen", 32'(seen_a), 32'b0100);
    chk("s1_last", 32'(last_a), 2);

    // all ports valid: round robin 0,1,2,3 every two cycles
    do_reset();
    va = 4'b1111;
    for (int r = 0; r < 2; r++) for (int p = 0; p < 4; p++) exp_a.push_back(p);
    step(16); va = '0; @(negedge clk);
    for (int p = 0; p < 4; p++) chk($sformatf("s2_cnt%0d", p), 32'(cnt_a[2*p +: 2]), ec(2));
    chk("s2_seen", 32'(seen_a), 32'b1111);
    chk("s2_last", 32'(last_a), 3);
    chk("s2_queue", exp_a.size(), 0);

    // saturation at 3 with a 2-bit counter
    do_reset();
    va = 4'b0001;
    repeat (5) exp_a.push_back(0);
    step(10); va = '0; @(negedge clk);
    chk("s3_cnt0_sat", 32'(cnt_a[1:0]), ec(3));
    chk("s3_seen", 32'(seen_a), 32'b0001);
    chk("s3_queue", exp_a.size(), 0);

    // flush coinciding with a port-3 handshake
    do_reset();
    va = 4'b1000;
    repeat (3) exp_a.push_back(3);
    step(4); @(negedge clk);
    chk("s4_cnt3_pre", 32'(cnt_a[7:6]), ec(2));
    step(); flush_a = 1'b1;
    step(); flush_a = 1'b0; va = '0; @(negedge clk);
    chk("s4_cnt3_post", 32'(cnt_a[7:6]), 0);
    chk("s4_seen", 32'(seen_a), 0);
    chk("s4_last", 32'(last_a), 3);
    chk("s4_queue", exp_a.size(), 0);

    // DrainLat 3: abort in WAIT, then re-grant of port 1
    do_reset();
    vb = 4'b0010; acc = '0;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) en_b = 1'b0;
      @(negedge clk); acc |= ready_b;
      step();
    end
    en_b = 1'b1; exp_b.push_back(1);
    @(negedge clk);
    chk("s5_abort_ready", 32'(acc), 0);
    chk("s5_abort_cnt", 32'(cnt_b[15:8]), 0);
    chk("s5_abort_seen", 32'(seen_b), 0);
    chk("s5_abort_busy", 32'(busy_b), 0);
    step(3); @(negedge clk);
    chk("s5_ready_c3", 32'(ready_b), 0);
    chk("s5_busy_c3", 32'(busy_b), 1);
    step(); @(negedge clk);
    chk("s5_ready_c4", 32'(ready_b), 32'b0010);
    step(); vb = '0; @(negedge clk);
    chk("s5_cnt1", 32'(cnt_b[15:8]), ec(1));
    chk("s5_seen", 32'(seen_b), 32'b0010);
    chk("s5_last", 32'(last_b), 1);
    chk("s5_queue", exp_b.size(), 0);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
